// File: rtl/branch_resolve_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolve_pkg
// Shared definitions for the execute-stage branch resolution unit and the
// fetch-side BTB that consumes its update port.
//   btb_iw()      : index width for a BTB of n entries
//   BTBNUM_DEF    : default BTB entry count
//   IW_DEF        : index width derived from BTBNUM_DEF
//   br_state_e    : resolve FSM encoding (RUN=0, REDIR=1)
//   btb_upd_t     : one BTB update beat, field-for-field the BTB write port
// ----------------------------------------------------------------------------
package branch_resolve_pkg;

  function automatic int btb_iw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int BTBNUM_DEF = 32;
  localparam int IW_DEF     = btb_iw(BTBNUM_DEF);

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } br_state_e;

  typedef struct packed {
    logic              pre_right;
    logic              pre_error;
    logic              target_error;
    logic [31:0]       right_target;
    logic [31:0]       operate_pc;
    logic [IW_DEF-1:0] operate_index;
  } btb_upd_t;

endpackage

// File: rtl/branch_resolve_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_if
// Bundles the resolved-branch input, the fetch-time prediction metadata, the
// BTB update pulses and the fetch redirect handshake.
//   modport master : EX / fetch side (drives resolve + prediction + ready)
//   modport slave  : branch_resolve (drives update pulses + redirect)
// ----------------------------------------------------------------------------
interface branch_resolve_if #(
  parameter int IW = branch_resolve_pkg::IW_DEF
) ();

  // Resolved branch from EX
  logic          br_valid;
  logic [31:0]   br_pc;
  logic          br_taken;
  logic [31:0]   br_target;
  // Prediction metadata carried from fetch
  logic          pre_en;
  logic          pre_taken;
  logic [31:0]   pre_target;
  logic [IW-1:0] pre_index;
  // BTB update port
  logic          pre_right;
  logic          pre_error;
  logic          target_error;
  logic [31:0]   right_target;
  logic [31:0]   operate_pc;
  logic [IW-1:0] operate_index;
  // Fetch redirect
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          redirect_ready;

  modport master (
    output br_valid, br_pc, br_taken, br_target,
    output pre_en, pre_taken, pre_target, pre_index,
    output redirect_ready,
    input  pre_right, pre_error, target_error, right_target, operate_pc,
    input  operate_index, redirect_valid, redirect_pc
  );

  modport slave (
    input  br_valid, br_pc, br_taken, br_target,
    input  pre_en, pre_taken, pre_target, pre_index,
    input  redirect_ready,
    output pre_right, pre_error, target_error, right_target, operate_pc,
    output operate_index, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
// Execute-stage branch resolution. Compares each resolved branch with the
// prediction made at fetch, emits one-cycle BTB update pulses, allocates BTB
// entries round-robin for taken branches that missed, and redirects fetch on
// a mispredict. While a redirect is pending every resolve is wrong-path and
// is dropped.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : branch_resolve_if.slave (resolve in, BTB update + redirect out)
//   stat_br_cnt / stat_mis_cnt : accepted / mispredicted resolve counters,
//            present only when BRANCH_STAT_EN is defined
//
// All update and redirect outputs come straight from registers, one cycle
// after the resolve is accepted.
// ----------------------------------------------------------------------------
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int BTBNUM = BTBNUM_DEF
) (
  input  logic                clk,
  input  logic                reset,
  branch_resolve_if.slave     bus
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0]         stat_br_cnt,
  output logic [31:0]         stat_mis_cnt
`endif
);

  localparam int IW = btb_iw(BTBNUM);

  br_state_e     state_q, state_d;
  btb_upd_t      upd_q, upd_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic [IW-1:0] alloc_ptr_q, alloc_ptr_d;

  // Mispredict compare: a BTB miss counts as a not-taken prediction.
  logic        ptk;
  logic        tgt_diff;
  logic        mis;
  logic        accept;
  logic [31:0] next_pc;

  assign ptk      = bus.pre_en & bus.pre_taken;
  assign tgt_diff = (bus.br_target != bus.pre_target);
  assign mis      = (bus.br_taken != ptk) | (bus.br_taken & ptk & tgt_diff);
  assign accept   = (state_q == RUN) & bus.br_valid;
  assign next_pc  = bus.br_taken ? bus.br_target : bus.br_pc + 32'd4;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    upd_d         = '0;
    redirect_pc_d = redirect_pc_q;
    alloc_ptr_d   = alloc_ptr_q;

    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (bus.pre_en) begin
            upd_d.pre_right     = ~mis;
            upd_d.pre_error     = mis;
            upd_d.target_error  = mis & bus.br_taken & tgt_diff;
            upd_d.operate_index = bus.pre_index;
          end else if (bus.br_taken) begin
            // Taken branch that missed in the BTB: claim the next entry.
            upd_d.pre_error     = 1'b1;
            upd_d.target_error  = 1'b1;
            upd_d.operate_index = IW_DEF'(alloc_ptr_q);
            alloc_ptr_d = (alloc_ptr_q == IW'(BTBNUM - 1)) ? '0
                                                           : alloc_ptr_q + 1'b1;
          end
          if (upd_d.pre_right | upd_d.pre_error) begin
            upd_d.right_target = bus.br_target;
            upd_d.operate_pc   = bus.br_pc;
          end
          if (mis) begin
            state_d       = REDIR;
            redirect_pc_d = next_pc;
          end
        end
      end
      REDIR: begin
        // Resolves seen here are wrong-path; only the handshake matters.
        if (bus.redirect_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      upd_q         <= '0;
      redirect_pc_q <= '0;
      alloc_ptr_q   <= '0;
    end else begin
      state_q       <= state_d;
      upd_q         <= upd_d;
      redirect_pc_q <= redirect_pc_d;
      alloc_ptr_q   <= alloc_ptr_d;
    end
  end

  assign bus.pre_right      = upd_q.pre_right;
  assign bus.pre_error      = upd_q.pre_error;
  assign bus.target_error   = upd_q.target_error;
  assign bus.right_target   = upd_q.right_target;
  assign bus.operate_pc     = upd_q.operate_pc;
  assign bus.operate_index  = upd_q.operate_index;
  assign bus.redirect_valid = (state_q == REDIR);
  assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (accept) begin
      stat_br_q <= stat_br_q + 32'd1;
      if (mis) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_br_cnt  = stat_br_q;
  assign stat_mis_cnt = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve
// Directed bench for branch_resolve. Each cycle the expected registered
// outputs are pushed to a scoreboard queue while the inputs are driven, then
// popped and compared one cycle later, #1 after the rising edge.
// ----------------------------------------------------------------------------
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic clk;
  logic reset;

  branch_resolve_if bus ();

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_br_cnt;
  logic [31:0] stat_mis_cnt;
`endif

  branch_resolve #(.BTBNUM(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BRANCH_STAT_EN
    ,
    .stat_br_cnt  (stat_br_cnt),
    .stat_mis_cnt (stat_mis_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pr;
    logic        pe;
    logic        te;
    logic [31:0] rt;
    logic [31:0] op;
    logic [4:0]  idx;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic pen,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic [4:0] pidx, input logic rdy);
    bus.br_valid       = v;
    bus.br_pc          = pc;
    bus.br_taken       = tk;
    bus.br_target      = tgt;
    bus.pre_en         = pen;
    bus.pre_taken      = ptk;
    bus.pre_target     = ptgt;
    bus.pre_index      = pidx;
    bus.redirect_ready = rdy;
  endtask

  task automatic push_exp(input string tag, input logic pr, input logic pe,
                          input logic te, input logic [31:0] rt,
                          input logic [31:0] op, input logic [4:0] idx,
                          input logic rv, input logic [31:0] rpc);
    exp_t e;
    e.tag = tag; e.pr = pr; e.pe = pe; e.te = te; e.rt = rt; e.op = op;
    e.idx = idx; e.rv = rv; e.rpc = rpc;
    sb.push_back(e);
  endtask

  task automatic push_idle(input string tag, input logic rv,
                           input logic [31:0] rpc);
    push_exp(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, rv, rpc);
  endtask

  // Advance one clock and compare the DUT against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pre_right"},      32'(bus.pre_right),      32'(e.pr));
      check({e.tag, ".pre_error"},      32'(bus.pre_error),      32'(e.pe));
      check({e.tag, ".target_error"},   32'(bus.target_error),   32'(e.te));
      check({e.tag, ".right_target"},   bus.right_target,        e.rt);
      check({e.tag, ".operate_pc"},     bus.operate_pc,          e.op);
      check({e.tag, ".operate_index"},  32'(bus.operate_index),  32'(e.idx));
      check({e.tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(e.rv));
      check({e.tag, ".redirect_pc"},    bus.redirect_pc,         e.rpc);
    end
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] tgt;

    // Reset state
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_idle("reset0", 0, 32'h0);
    tick();
    push_idle("reset1", 0, 32'h0);
    tick();
    reset = 1'b0;

    // Correct hit, then a back-to-back correct hit, then idle
    drive(1, 32'h100, 1, 32'h1000, 1, 1, 32'h1000, 5'd3, 0);
    push_exp("hit_a", 1, 0, 0, 32'h1000, 32'h100, 5'd3, 0, 32'h0);
    tick();
    drive(1, 32'h104, 1, 32'h1000, 1, 1, 32'h1000, 5'd7, 0);
    push_exp("hit_b", 1, 0, 0, 32'h1000, 32'h104, 5'd7, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_idle("hit_end", 0, 32'h0);
    tick();

    // Direction mispredict: predicted taken, actually falls through
    drive(1, 32'h2000, 0, 32'h2100, 1, 1, 32'h2100, 5'd5, 0);
    push_exp("dir_mis", 0, 1, 0, 32'h2100, 32'h2000, 5'd5, 1, 32'h2004);
    tick();

    // Wrong-path resolves in REDIR (would allocate if accepted)
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h2400 + 32'(4 * i), 1, 32'h9900, 0, 0, 0, 0, 0);
      push_idle("wrong_path", 1, 32'h2004);
      tick();
    end

    // Handshake with a same-cycle resolve that must be discarded
    drive(1, 32'h2500, 1, 32'h9a00, 0, 0, 0, 0, 1);
    push_idle("handshake_drop", 0, 32'h2004);
    tick();

    // BTB miss, not taken: no pulses, no redirect
    drive(1, 32'h2600, 0, 32'h9b00, 0, 0, 0, 0, 0);
    push_idle("miss_nt", 0, 32'h2004);
    tick();

    // Target mispredict
    drive(1, 32'h30f0, 1, 32'h3400, 1, 1, 32'h3000, 5'd9, 0);
    push_exp("tgt_mis", 0, 1, 1, 32'h3400, 32'h30f0, 5'd9, 1, 32'h3400);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    push_idle("tgt_mis_hs", 0, 32'h3400);
    tick();

    // Allocation wrap: 33 taken misses starting from entry 0
    for (int i = 0; i < 33; i++) begin
      pc  = 32'h4000 + 32'(4 * i);
      tgt = 32'h8000 + 32'(16 * i);
      drive(1, pc, 1, tgt, 0, 0, 0, 0, 0);
      push_exp("alloc", 0, 1, 1, tgt, pc, 5'(i % 32), 1, tgt);
      tick();
      drive(1, 32'hdead_0000, 1, 32'h5555_0000, 0, 0, 0, 0, 1);
      push_idle("alloc_hs", 0, tgt);
      tick();
    end

    // Reset while a redirect is pending
    drive(1, 32'h6000, 0, 32'h6100, 1, 1, 32'h6100, 5'd2, 0);
    push_exp("pre_rst_mis", 0, 1, 0, 32'h6100, 32'h6000, 5'd2, 1, 32'h6004);
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_idle("rst_in_redir", 0, 32'h0);
    tick();
    reset = 1'b0;
    drive(1, 32'h7000, 1, 32'h7100, 1, 1, 32'h7100, 5'd4, 0);
    push_exp("post_rst_hit", 1, 0, 0, 32'h7100, 32'h7000, 5'd4, 0, 32'h0);
    tick();
`ifdef BRANCH_STAT_EN
    check("stat_br_cnt",  stat_br_cnt,  32'd1);
    check("stat_mis_cnt", stat_mis_cnt, 32'd0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_idle("final_idle", 0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
